// File: rtl/id_stage_pipelined_if.sv
// IF/ID-to-EX bundle for the decode stage: instruction input, write-back port,
// pipeline control and the registered ID/EX fields handed to EX.
interface id_stage_pipelined_if #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  parameter int PC_W      = 32
);
  localparam int AW = $clog2(REG_COUNT);

  logic              in_valid;
  logic [PC_W-1:0]   pc_in;
  logic [31:0]       instruction;
  logic              stall_in;
  logic              flush;
  logic              wb_en;
  logic [AW-1:0]     wb_dest;
  logic [DATA_W-1:0] wb_data;

  logic              hazard_stall;
  logic              valid_out;
  logic [PC_W-1:0]   pc_out;
  logic [3:0]        ex_cmd;
  logic              mem_read;
  logic              mem_write;
  logic              wb_enable;
  logic              branch_type;
  logic [DATA_W-1:0] reg1;
  logic [DATA_W-1:0] reg2;
  logic [DATA_W-1:0] operand_b;
  logic [AW-1:0]     dest;

  modport master (
    output in_valid, pc_in, instruction, stall_in, flush, wb_en, wb_dest, wb_data,
    input  hazard_stall, valid_out, pc_out, ex_cmd, mem_read, mem_write,
           wb_enable, branch_type, reg1, reg2, operand_b, dest
  );

  modport slave (
    input  in_valid, pc_in, instruction, stall_in, flush, wb_en, wb_dest, wb_data,
    output hazard_stall, valid_out, pc_out, ex_cmd, mem_read, mem_write,
           wb_enable, branch_type, reg1, reg2, operand_b, dest
  );
endinterface

// File: rtl/id_stage_pipelined.sv
// Instruction decode with register file (write-through bypass), load-use
// hazard detection and the ID/EX pipeline register.
module id_stage_pipelined #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  parameter int PC_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  id_stage_pipelined_if.slave bus
);
  localparam int AW = $clog2(REG_COUNT);

  typedef enum logic [5:0] {
    OP_ADD  = 6'h01,
    OP_SUB  = 6'h03,
    OP_AND  = 6'h05,
    OP_OR   = 6'h06,
    OP_ADDI = 6'h20,
    OP_LD   = 6'h24,
    OP_ST   = 6'h25,
    OP_BEZ  = 6'h28
  } opcode_e;

  typedef struct packed {
    logic [3:0] ex_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_enable;
    logic       branch_type;
  } ctrl_t;

  logic [5:0]        opcode;
  logic [AW-1:0]     rs1, rs2, rd;
  logic [DATA_W-1:0] imm_ext;

  assign opcode  = bus.instruction[31:26];
  assign rs1     = bus.instruction[21 +: AW];
  assign rs2     = bus.instruction[16 +: AW];
  assign rd      = bus.instruction[11 +: AW];
  assign imm_ext = {{(DATA_W-16){bus.instruction[15]}}, bus.instruction[15:0]};

  ctrl_t         dec_ctrl;
  logic          dec_is_imm;
  logic          dec_rs2_used;
  logic [AW-1:0] dec_dest;

  // NOTE: every output of a combinational block gets a default before the
  // case; a path that leaves one unassigned would infer a latch.
  always_comb begin
    dec_ctrl     = '0;
    dec_is_imm   = 1'b0;
    dec_rs2_used = 1'b0;
    dec_dest     = '0;
    case (opcode)
      OP_ADD:  begin dec_ctrl.ex_cmd = 4'b0000; dec_ctrl.wb_enable = 1'b1; dec_rs2_used = 1'b1; dec_dest = rd; end
      OP_SUB:  begin dec_ctrl.ex_cmd = 4'b0010; dec_ctrl.wb_enable = 1'b1; dec_rs2_used = 1'b1; dec_dest = rd; end
      OP_AND:  begin dec_ctrl.ex_cmd = 4'b0100; dec_ctrl.wb_enable = 1'b1; dec_rs2_used = 1'b1; dec_dest = rd; end
      OP_OR:   begin dec_ctrl.ex_cmd = 4'b0101; dec_ctrl.wb_enable = 1'b1; dec_rs2_used = 1'b1; dec_dest = rd; end
      OP_ADDI: begin dec_ctrl.wb_enable = 1'b1; dec_is_imm = 1'b1; dec_dest = rs2; end
      OP_LD:   begin dec_ctrl.mem_read = 1'b1; dec_ctrl.wb_enable = 1'b1; dec_is_imm = 1'b1; dec_dest = rs2; end
      OP_ST:   begin dec_ctrl.mem_write = 1'b1; dec_is_imm = 1'b1; dec_rs2_used = 1'b1; end
      OP_BEZ:  begin dec_ctrl.branch_type = 1'b1; dec_is_imm = 1'b1; dec_rs2_used = 1'b1; end
      default: ;
    endcase
  end

  logic [DATA_W-1:0] regs [REG_COUNT];
  logic              wb_live;

  assign wb_live = bus.wb_en && (bus.wb_dest != '0);

  // NOTE: the register file has to come out of reset all-zero, so the array
  // sits in a reset branch; RAM macros without reset cannot hold it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wb_live) begin
      regs[bus.wb_dest] <= bus.wb_data;
    end
  end

  logic [DATA_W-1:0] rs1_val, rs2_val;

  // r0 is hard zero; a write landing this cycle is forwarded to the reader
  assign rs1_val = (rs1 == '0) ? '0 : (wb_live && bus.wb_dest == rs1) ? bus.wb_data : regs[rs1];
  assign rs2_val = (rs2 == '0) ? '0 : (wb_live && bus.wb_dest == rs2) ? bus.wb_data : regs[rs2];

  logic              valid_q;
  logic [PC_W-1:0]   pc_q;
  ctrl_t             ctrl_q;
  logic [DATA_W-1:0] reg1_q, reg2_q, operand_b_q;
  logic [AW-1:0]     dest_q;

  assign bus.hazard_stall = rst && !bus.flush && bus.in_valid && valid_q && ctrl_q.mem_read &&
                            (dest_q != '0) &&
                            ((dest_q == rs1) || (dec_rs2_used && dest_q == rs2));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, matching the hardware regardless of order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      ctrl_q      <= '0;
      reg1_q      <= '0;
      reg2_q      <= '0;
      operand_b_q <= '0;
      dest_q      <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      dest_q  <= '0;
    end else if (bus.stall_in) begin
      // hold everything, including a pending load that is causing a hazard
    end else if (bus.in_valid && !bus.hazard_stall) begin
      valid_q     <= 1'b1;
      pc_q        <= bus.pc_in;
      ctrl_q      <= dec_ctrl;
      reg1_q      <= rs1_val;
      reg2_q      <= rs2_val;
      operand_b_q <= dec_is_imm ? imm_ext : rs2_val;
      dest_q      <= dec_dest;
    end else begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      dest_q  <= '0;
    end
  end

  assign bus.valid_out   = valid_q;
  assign bus.pc_out      = pc_q;
  assign bus.ex_cmd      = ctrl_q.ex_cmd;
  assign bus.mem_read    = ctrl_q.mem_read;
  assign bus.mem_write   = ctrl_q.mem_write;
  assign bus.wb_enable   = ctrl_q.wb_enable;
  assign bus.branch_type = ctrl_q.branch_type;
  assign bus.reg1        = reg1_q;
  assign bus.reg2        = reg2_q;
  assign bus.operand_b   = operand_b_q;
  assign bus.dest        = dest_q;
endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed bench for id_stage_pipelined: decode, bypass, load-use stall,
// flush/stall priority, r0 behaviour and asynchronous reset.
module tb_id_stage_pipelined;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  id_stage_pipelined_if #(.DATA_W(32), .REG_COUNT(32), .PC_W(32)) bus ();

  id_stage_pipelined #(.DATA_W(32), .REG_COUNT(32), .PC_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] a,
                                      input logic [4:0] b, input logic [15:0] low);
    return {op, a, b, low};
  endfunction

  // advance one rising edge and settle away from it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    bus.instruction = ins;
    bus.pc_in       = pc;
    bus.in_valid    = 1'b1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".valid"},  bus.valid_out, 0);
    check({tag, ".pc"},     bus.pc_out, 0);
    check({tag, ".ctrl"},   {bus.ex_cmd, bus.mem_read, bus.mem_write, bus.wb_enable, bus.branch_type}, 0);
    check({tag, ".regs"},   {bus.reg1, bus.reg2}, 0);
    check({tag, ".opb"},    bus.operand_b, 0);
    check({tag, ".dest"},   bus.dest, 0);
    check({tag, ".hazard"}, bus.hazard_stall, 0);
  endtask

  initial begin
    rst             = 1'b0;
    bus.in_valid    = 1'b0;
    bus.pc_in       = '0;
    bus.instruction = '0;
    bus.stall_in    = 1'b0;
    bus.flush       = 1'b0;
    bus.wb_en       = 1'b0;
    bus.wb_dest     = '0;
    bus.wb_data     = '0;
    #12;
    check_zero_outputs("reset0");
    @(negedge clk);
    rst = 1'b1;

    // preload r1 = 7, r2 = 9
    bus.wb_en = 1'b1; bus.wb_dest = 5'd1; bus.wb_data = 32'd7;
    cyc();
    bus.wb_dest = 5'd2; bus.wb_data = 32'd9;
    cyc();
    bus.wb_en = 1'b0;
    check("idle.valid", bus.valid_out, 0);

    // ADD r3 = r1 + r2
    issue(enc(6'h01, 5'd1, 5'd2, 16'h1800), 32'h100);
    cyc();
    check("add.valid", bus.valid_out, 1);
    check("add.pc", bus.pc_out, 32'h100);
    check("add.reg1", bus.reg1, 7);
    check("add.reg2", bus.reg2, 9);
    check("add.opb", bus.operand_b, 9);
    check("add.cmd", bus.ex_cmd, 4'b0000);
    check("add.wb", bus.wb_enable, 1);
    check("add.mem", {bus.mem_read, bus.mem_write, bus.branch_type}, 0);
    check("add.dest", bus.dest, 3);

    // ADDI r4, r1, -2 with a same-cycle write-back of 0x55 to r1
    issue(enc(6'h20, 5'd1, 5'd4, 16'hFFFE), 32'h104);
    bus.wb_en = 1'b1; bus.wb_dest = 5'd1; bus.wb_data = 32'h55;
    cyc();
    bus.wb_en = 1'b0;
    check("addi.reg1_bypass", bus.reg1, 32'h55);
    check("addi.opb", bus.operand_b, 32'hFFFF_FFFE);
    check("addi.dest", bus.dest, 4);
    check("addi.wb", bus.wb_enable, 1);

    // LD r2 then ADD r5, r2, r1 -> one-cycle stall
    issue(enc(6'h24, 5'd1, 5'd2, 16'h0004), 32'h108);
    cyc();
    check("ld.mem_read", bus.mem_read, 1);
    check("ld.dest", bus.dest, 2);
    check("ld.opb", bus.operand_b, 4);
    issue(enc(6'h01, 5'd2, 5'd1, 16'h2800), 32'h10C);
    #1;
    check("lu.hazard", bus.hazard_stall, 1);
    cyc();
    check("lu.bubble_valid", bus.valid_out, 0);
    check("lu.bubble_wb", bus.wb_enable, 0);
    check("lu.bubble_mr", bus.mem_read, 0);
    check("lu.hazard_clear", bus.hazard_stall, 0);
    cyc();
    check("lu.add_valid", bus.valid_out, 1);
    check("lu.add_pc", bus.pc_out, 32'h10C);
    check("lu.add_dest", bus.dest, 5);
    check("lu.add_reg1", bus.reg1, 9);
    check("lu.add_reg2", bus.reg2, 32'h55);

    // LD r2 then ADDI r7, r1, 1 (rs2 field is a dest) -> no stall
    issue(enc(6'h24, 5'd1, 5'd2, 16'h0004), 32'h110);
    cyc();
    issue(enc(6'h20, 5'd1, 5'd7, 16'h0001), 32'h114);
    #1;
    check("noh.hazard", bus.hazard_stall, 0);
    cyc();
    check("noh.valid", bus.valid_out, 1);
    check("noh.dest", bus.dest, 7);
    check("noh.opb", bus.operand_b, 1);

    // LD r2 then ST using r2 as rs2 -> stall, then ST issues
    issue(enc(6'h24, 5'd1, 5'd2, 16'h0004), 32'h118);
    cyc();
    issue(enc(6'h25, 5'd1, 5'd2, 16'h0008), 32'h11C);
    #1;
    check("st.hazard_rs2", bus.hazard_stall, 1);
    cyc();
    check("st.bubble_mw", bus.mem_write, 0);
    cyc();
    check("st.valid", bus.valid_out, 1);
    check("st.mem_write", bus.mem_write, 1);
    check("st.wb", bus.wb_enable, 0);
    check("st.dest", bus.dest, 0);
    check("st.opb", bus.operand_b, 8);

    // flush while a ST is being decoded
    issue(enc(6'h25, 5'd1, 5'd2, 16'h0008), 32'h120);
    bus.flush = 1'b1;
    cyc();
    check("flush.valid", bus.valid_out, 0);
    check("flush.mem_write", bus.mem_write, 0);
    bus.flush = 1'b0;

    // flush masks a load-use hazard
    issue(enc(6'h24, 5'd1, 5'd2, 16'h0004), 32'h124);
    cyc();
    issue(enc(6'h01, 5'd2, 5'd1, 16'h2800), 32'h128);
    bus.flush = 1'b1;
    #1;
    check("flush.hazard_masked", bus.hazard_stall, 0);
    cyc();
    check("flush.ld_squashed", bus.mem_read, 0);
    bus.flush = 1'b0;

    // flush together with stall_in -> flush wins
    issue(enc(6'h01, 5'd1, 5'd2, 16'h1800), 32'h12C);
    cyc();
    check("fs.pre_valid", bus.valid_out, 1);
    bus.stall_in = 1'b1; bus.flush = 1'b1;
    cyc();
    check("fs.valid", bus.valid_out, 0);
    check("fs.wb", bus.wb_enable, 0);
    bus.stall_in = 1'b0; bus.flush = 1'b0;

    // SUB r8 then stall_in for 3 cycles while OR r9 waits
    issue(enc(6'h03, 5'd1, 5'd2, 16'h4000), 32'h200);
    cyc();
    check("sub.cmd", bus.ex_cmd, 4'b0010);
    check("sub.dest", bus.dest, 8);
    issue(enc(6'h06, 5'd2, 5'd1, 16'h4800), 32'h300);
    bus.stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("hold.state", {bus.valid_out, bus.pc_out, bus.ex_cmd, bus.dest}, {1'b1, 32'h200, 4'b0010, 5'd8});
      check("hold.regs", {bus.reg1, bus.reg2}, {32'h55, 32'd9});
    end
    bus.stall_in = 1'b0;
    cyc();
    check("or.cmd", bus.ex_cmd, 4'b0101);
    check("or.dest", bus.dest, 9);
    check("or.pc", bus.pc_out, 32'h300);

    // stall_in with a pending load-use hazard: hold wins, hazard stays up
    issue(enc(6'h24, 5'd1, 5'd2, 16'h0004), 32'h304);
    cyc();
    issue(enc(6'h01, 5'd2, 5'd1, 16'h2800), 32'h308);
    bus.stall_in = 1'b1;
    cyc();
    check("sh.ld_held", {bus.mem_read, bus.pc_out}, {1'b1, 32'h304});
    check("sh.hazard", bus.hazard_stall, 1);
    bus.stall_in = 1'b0;
    cyc();
    check("sh.bubble", bus.valid_out, 0);
    cyc();
    check("sh.add_pc", bus.pc_out, 32'h308);

    // writes to r0 are dropped, even on the bypass path
    issue(enc(6'h01, 5'd0, 5'd0, 16'h5000), 32'h30C);
    bus.wb_en = 1'b1; bus.wb_dest = 5'd0; bus.wb_data = 32'hDEAD;
    cyc();
    check("r0.bypass", {bus.reg1, bus.reg2}, 0);
    check("r0.dest", bus.dest, 10);
    bus.wb_en = 1'b0;
    cyc();
    check("r0.stored", {bus.reg1, bus.reg2}, 0);

    // remaining decodes: AND, BEZ, unknown, 0x00
    issue(enc(6'h05, 5'd1, 5'd2, 16'h5800), 32'h310);
    cyc();
    check("and.cmd", {bus.ex_cmd, bus.wb_enable, bus.dest}, {4'b0100, 1'b1, 5'd11});
    issue(enc(6'h28, 5'd1, 5'd2, 16'hFFF0), 32'h314);
    cyc();
    check("bez.ctrl", {bus.ex_cmd, bus.mem_read, bus.mem_write, bus.wb_enable, bus.branch_type}, 8'b0000_0001);
    check("bez.opb", bus.operand_b, 32'hFFFF_FFF0);
    check("bez.dest", bus.dest, 0);
    issue(enc(6'h3F, 5'd1, 5'd2, 16'h1800), 32'h318);
    cyc();
    check("nop3f", {bus.valid_out, bus.ex_cmd, bus.mem_read, bus.mem_write, bus.wb_enable, bus.branch_type, bus.dest},
          {1'b1, 4'b0, 4'b0, 5'd0});
    issue(enc(6'h00, 5'd1, 5'd2, 16'h1800), 32'h31C);
    cyc();
    check("nop00", {bus.valid_out, bus.ex_cmd, bus.wb_enable, bus.dest}, {1'b1, 4'b0, 1'b0, 5'd0});

    // reset in the middle of a load-use stall
    bus.in_valid = 1'b0;
    bus.wb_en = 1'b1; bus.wb_dest = 5'd5; bus.wb_data = 32'h1234;
    cyc();
    bus.wb_en = 1'b0;
    issue(enc(6'h24, 5'd1, 5'd2, 16'h0004), 32'h400);
    cyc();
    issue(enc(6'h01, 5'd2, 5'd5, 16'h0800), 32'h404);
    #1;
    check("rst.pre_hazard", bus.hazard_stall, 1);
    rst = 1'b0;
    #1;
    check_zero_outputs("reset_mid");
    cyc();
    rst = 1'b1;
    issue(enc(6'h01, 5'd5, 5'd0, 16'h0800), 32'h408);
    cyc();
    check("rst.r5_cleared", bus.reg1, 0);
    check("rst.valid", bus.valid_out, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
